// File: rtl/ddr3_bist_pkg.sv
// Shared types for the DDR3 BIST engine: FSM states, pattern modes and
// LFSR feedback masks.
package ddr3_bist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_READ  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [1:0] MODE_INC  = 2'd0;
    localparam logic [1:0] MODE_WALK = 2'd1;
    localparam logic [1:0] MODE_LFSR = 2'd2;
    localparam logic [1:0] MODE_ADDR = 2'd3;

    // Fibonacci feedback mask: bit k set means state bit k feeds the XOR.
    function automatic logic [63:0] lfsr_taps(input int width);
        logic [63:0] taps;
        case (width)
            8:       taps = 64'h0000_0000_0000_00B8;
            16:      taps = 64'h0000_0000_0000_B400;
            32:      taps = 64'h0000_0000_8020_0003;
            64:      taps = 64'hD800_0000_0000_0000;
            default: taps = 64'h3 << (width - 2);
        endcase
        return taps;
    endfunction

endpackage

// File: rtl/ddr3_bist_if.sv
// User-port bundle between the BIST engine (master) and the memory controller (slave).
// A request transfers on a cycle where (write_enable || read_enable) && req_ready; while a request
// is pending the master holds the enable, user_address and user_wdata unchanged, and it never raises
// both enables together. rd_valid/rd_data carry read returns in issue order, with no backpressure.
interface ddr3_bist_if #(
    parameter int AW = 18,
    parameter int DW = 16
);
    logic          req_ready;
    logic          write_enable;
    logic          read_enable;
    logic [AW-1:0] user_address;
    logic [DW-1:0] user_wdata;
    logic          rd_valid;
    logic [DW-1:0] rd_data;

    modport master (
        output write_enable, read_enable, user_address, user_wdata,
        input  req_ready, rd_valid, rd_data
    );

    modport slave (
        input  write_enable, read_enable, user_address, user_wdata,
        output req_ready, rd_valid, rd_data
    );
endinterface

// File: rtl/ddr3_bist_pattern.sv
// Maps a word index, address and LFSR state to pattern data for the selected mode,
// and gives the next LFSR state so the caller can step it per word.
module ddr3_bist_pattern
    import ddr3_bist_pkg::*;
#(
    parameter int ADDR_W = 18,
    parameter int DQ_W   = 16,
    parameter int LEN_W  = 16
) (
    input  logic [1:0]        mode_i,
    input  logic [LEN_W-1:0]  index_i,
    input  logic [ADDR_W-1:0] address_i,
    input  logic [DQ_W-1:0]   lfsr_i,
    output logic [DQ_W-1:0]   data_o,
    output logic [DQ_W-1:0]   lfsr_next_o
);
    localparam logic [DQ_W-1:0]  TAPS = DQ_W'(lfsr_taps(DQ_W));
    localparam logic [LEN_W-1:0] DQ_L = LEN_W'(DQ_W);

    logic [LEN_W-1:0] walk_sh;

    always_comb begin
        walk_sh     = index_i % DQ_L;
        lfsr_next_o = {lfsr_i[DQ_W-2:0], ^(lfsr_i & TAPS)};
        case (mode_i)
            MODE_INC:  data_o = DQ_W'(index_i);
            MODE_WALK: data_o = DQ_W'(1) << walk_sh;
            MODE_LFSR: data_o = lfsr_i;
            default:   data_o = DQ_W'(address_i);
        endcase
    end
endmodule

// File: rtl/ddr3_bist.sv
// DDR3 BIST traffic engine: writes a pattern over a region, reads it back with bounded
// outstanding reads, and checks each return against an independently regenerated stream.
module ddr3_bist
    import ddr3_bist_pkg::*;
#(
    parameter int ADDRESS_BITWIDTH      = 15,
    parameter int BANK_ADDRESS_BITWIDTH = 3,
    parameter int DQ_BITWIDTH           = 16,
    parameter int LEN_BITWIDTH          = 16,
    parameter int MAX_OUTSTANDING       = 8,
    parameter int ERR_BITWIDTH          = 16,
    parameter logic [DQ_BITWIDTH-1:0] LFSR_SEED = 16'hACE1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [1:0]            mode,
    input  logic [BANK_ADDRESS_BITWIDTH+ADDRESS_BITWIDTH-1:0] base_address,
    input  logic [LEN_BITWIDTH-1:0] len,
    ddr3_bist_if.master           bus,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ERR_BITWIDTH-1:0] error_count,
    output logic [BANK_ADDRESS_BITWIDTH+ADDRESS_BITWIDTH-1:0] first_err_address,
    output logic [DQ_BITWIDTH-1:0] first_err_data,
    output state_t                dbg_state
);
    localparam int AW = BANK_ADDRESS_BITWIDTH + ADDRESS_BITWIDTH;
    localparam int DW = DQ_BITWIDTH;
    localparam int LW = LEN_BITWIDTH;
    localparam int EW = ERR_BITWIDTH;
    localparam int OW = $clog2(MAX_OUTSTANDING) + 1;
    localparam logic [OW-1:0] MAX_OUT = OW'(MAX_OUTSTANDING);
    localparam logic [LW-1:0] L_ONE = LW'(1);
    localparam logic [AW-1:0] A_ONE = AW'(1);
    localparam logic [EW-1:0] E_ONE = EW'(1);

    state_t        state_q, state_d;
    logic [1:0]    mode_q, mode_d;
    logic [AW-1:0] base_q, base_d;
    logic [LW-1:0] len_q, len_d;
    logic [LW-1:0] iss_idx_q, iss_idx_d;
    logic [AW-1:0] iss_addr_q, iss_addr_d;
    logic [DW-1:0] iss_lfsr_q, iss_lfsr_d;
    logic [LW-1:0] chk_idx_q, chk_idx_d;
    logic [AW-1:0] chk_addr_q, chk_addr_d;
    logic [DW-1:0] chk_lfsr_q, chk_lfsr_d;
    logic [OW-1:0] out_q, out_d;
    logic [EW-1:0] err_q, err_d;
    logic [AW-1:0] ferr_addr_q, ferr_addr_d;
    logic [DW-1:0] ferr_data_q, ferr_data_d;
    logic          pass_q, pass_d;

    logic          we, re, wr_acc, rd_acc, chk_fire, iss_last, start_go;
    logic [DW-1:0] iss_data, iss_lfsr_next, chk_data, chk_lfsr_next;

    ddr3_bist_pattern #(.ADDR_W(AW), .DQ_W(DW), .LEN_W(LW)) u_iss_pat (
        .mode_i(mode_q), .index_i(iss_idx_q), .address_i(iss_addr_q), .lfsr_i(iss_lfsr_q),
        .data_o(iss_data), .lfsr_next_o(iss_lfsr_next)
    );

    ddr3_bist_pattern #(.ADDR_W(AW), .DQ_W(DW), .LEN_W(LW)) u_chk_pat (
        .mode_i(mode_q), .index_i(chk_idx_q), .address_i(chk_addr_q), .lfsr_i(chk_lfsr_q),
        .data_o(chk_data), .lfsr_next_o(chk_lfsr_next)
    );

    assign start_go = (state_q == ST_IDLE) && start;
    assign iss_last = (iss_idx_q == len_q - L_ONE);
    assign wr_acc   = we && bus.req_ready;
    assign rd_acc   = re && bus.req_ready;
    // A return only counts while reads are in flight; it may coincide with the accept of a zero-latency read.
    assign chk_fire = bus.rd_valid && (state_q == ST_READ || state_q == ST_DRAIN)
                      && (chk_idx_q != len_q) && (out_q != '0 || rd_acc);

    always_comb begin
        state_d = state_q;
        we      = 1'b0;
        re      = 1'b0;
        case (state_q)
            ST_IDLE:  if (start) state_d = (len == '0) ? ST_DONE : ST_WRITE;
            ST_WRITE: begin
                we = 1'b1;
                if (bus.req_ready && iss_last) state_d = ST_READ;
            end
            ST_READ: begin
                re = (out_q < MAX_OUT);
                if (re && bus.req_ready && iss_last) state_d = ST_DRAIN;
            end
            ST_DRAIN: if (chk_idx_q == len_q) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        mode_d      = mode_q;
        base_d      = base_q;
        len_d       = len_q;
        iss_idx_d   = iss_idx_q;
        iss_addr_d  = iss_addr_q;
        iss_lfsr_d  = iss_lfsr_q;
        chk_idx_d   = chk_idx_q;
        chk_addr_d  = chk_addr_q;
        chk_lfsr_d  = chk_lfsr_q;
        out_d       = out_q + OW'(rd_acc) - OW'(chk_fire);
        err_d       = err_q;
        ferr_addr_d = ferr_addr_q;
        ferr_data_d = ferr_data_q;
        pass_d      = pass_q;

        if (start_go) begin
            mode_d      = mode;
            base_d      = base_address;
            len_d       = len;
            iss_idx_d   = '0;
            iss_addr_d  = base_address;
            iss_lfsr_d  = LFSR_SEED;
            chk_idx_d   = '0;
            chk_addr_d  = base_address;
            chk_lfsr_d  = LFSR_SEED;
            out_d       = '0;
            err_d       = '0;
            ferr_addr_d = '0;
            ferr_data_d = '0;
            pass_d      = 1'b0;
        end

        // The issue counters are rewound to the base when the write phase ends and reused for reads.
        if (wr_acc) begin
            if (iss_last) begin
                iss_idx_d  = '0;
                iss_addr_d = base_q;
            end else begin
                iss_idx_d  = iss_idx_q + L_ONE;
                iss_addr_d = iss_addr_q + A_ONE;
                iss_lfsr_d = iss_lfsr_next;
            end
        end
        if (rd_acc) begin
            iss_idx_d  = iss_idx_q + L_ONE;
            iss_addr_d = iss_addr_q + A_ONE;
        end

        if (chk_fire) begin
            chk_idx_d  = chk_idx_q + L_ONE;
            chk_addr_d = chk_addr_q + A_ONE;
            chk_lfsr_d = chk_lfsr_next;
            if (bus.rd_data != chk_data) begin
                if (err_q != '1) err_d = err_q + E_ONE;
                if (err_q == '0) begin
                    ferr_addr_d = chk_addr_q;
                    ferr_data_d = bus.rd_data;
                end
            end
        end

        if (state_d == ST_DONE && state_q != ST_DONE) pass_d = (err_d == '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            mode_q      <= '0;
            base_q      <= '0;
            len_q       <= '0;
            iss_idx_q   <= '0;
            iss_addr_q  <= '0;
            iss_lfsr_q  <= '0;
            chk_idx_q   <= '0;
            chk_addr_q  <= '0;
            chk_lfsr_q  <= '0;
            out_q       <= '0;
            err_q       <= '0;
            ferr_addr_q <= '0;
            ferr_data_q <= '0;
            pass_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            base_q      <= base_d;
            len_q       <= len_d;
            iss_idx_q   <= iss_idx_d;
            iss_addr_q  <= iss_addr_d;
            iss_lfsr_q  <= iss_lfsr_d;
            chk_idx_q   <= chk_idx_d;
            chk_addr_q  <= chk_addr_d;
            chk_lfsr_q  <= chk_lfsr_d;
            out_q       <= out_d;
            err_q       <= err_d;
            ferr_addr_q <= ferr_addr_d;
            ferr_data_q <= ferr_data_d;
            pass_q      <= pass_d;
        end
    end

    assign bus.write_enable = we;
    assign bus.read_enable  = re;
    assign bus.user_address = (we || re) ? iss_addr_q : '0;
    assign bus.user_wdata   = we ? iss_data : '0;

    assign busy              = (state_q != ST_IDLE);
    assign done              = (state_q == ST_DONE);
    assign pass              = pass_q;
    assign error_count       = err_q;
    assign first_err_address = ferr_addr_q;
    assign first_err_data    = ferr_data_q;
    assign dbg_state         = state_q;
endmodule

// File: tb/tb_ddr3_bist.sv
// Randomised bench for ddr3_bist: a memory/loopback model answers requests, and a
// scoreboard checks every request and each end-of-test result against a reference model.
module tb_ddr3_bist;
    import ddr3_bist_pkg::*;

    localparam int AW   = 18;
    localparam int DW   = 16;
    localparam int LW   = 16;
    localparam int EW   = 16;
    localparam int MAXO = 8;
    localparam logic [DW-1:0] SEED = 16'hACE1;

    logic          clk = 1'b0;
    logic          reset, start;
    logic [1:0]    mode;
    logic [AW-1:0] base_address;
    logic [LW-1:0] len;
    logic          busy, done, pass;
    logic [EW-1:0] error_count;
    logic [AW-1:0] first_err_address;
    logic [DW-1:0] first_err_data;
    state_t        dbg_state;

    ddr3_bist_if #(.AW(AW), .DW(DW)) bus ();

    ddr3_bist dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode),
        .base_address(base_address), .len(len), .bus(bus),
        .busy(busy), .done(done), .pass(pass), .error_count(error_count),
        .first_err_address(first_err_address), .first_err_data(first_err_data),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    typedef struct packed {
        logic [EW-1:0] err;
        logic          p;
        logic [AW-1:0] fa;
        logic [DW-1:0] fd;
    } res_t;
    typedef struct {
        int            due;
        logic [DW-1:0] d;
    } rd_t;

    logic [AW+DW-1:0] exp_q[$];
    logic [AW-1:0]    exp_rd_q[$];
    res_t             exp_res_q[$];
    rd_t              pipe[$];
    logic [DW-1:0]    mem [logic [AW-1:0]];

    int total = 0, bad = 0;
    int cyc = 0, lat = 3, hold_until = 0, corrupt_idx = -1;
    int rd_issued = 0, outstanding = 0, last_rdv = 0, done_cnt = 0, cur_len = 0;
    bit rand_ready = 0;
    logic [DW-1:0] corrupt_mask = '0;
    bit pend_v = 0;
    logic [63:0] pend = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name, input string what);
        total++;
        bad++;
        $display("FAIL %s: %s", name, what);
    endtask

    // ---------------- reference model ----------------
    function automatic logic [DW-1:0] lfsr_next(input logic [DW-1:0] x);
        return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
    endfunction

    function automatic logic [DW-1:0] ref_word(input int m, input int i, input logic [AW-1:0] a,
                                               input logic [DW-1:0] l);
        case (m)
            0:       return DW'(i);
            1:       return DW'(1) << (i % DW);
            2:       return l;
            default: return a[DW-1:0];
        endcase
    endfunction

    task automatic push_expect(input int m, input logic [AW-1:0] b, input int n,
                               input int cidx, input logic [DW-1:0] cmask);
        logic [DW-1:0] l, d;
        logic [AW-1:0] a;
        res_t r;
        int errs;
        l = SEED;
        errs = 0;
        r = '0;
        for (int i = 0; i < n; i++) begin
            a = b + AW'(i);
            d = ref_word(m, i, a, l);
            exp_q.push_back({a, d});
            exp_rd_q.push_back(a);
            if (i == cidx && cmask != '0) begin
                if (errs == 0) begin
                    r.fa = a;
                    r.fd = d ^ cmask;
                end
                errs++;
            end
            l = lfsr_next(l);
        end
        r.err = EW'(errs);
        r.p   = (errs == 0);
        exp_res_q.push_back(r);
    endtask

    // ---------------- memory model + monitor (sample at posedge) ----------------
    always @(posedge clk) begin
        logic [DW-1:0] d;
        logic [AW+DW-1:0] e;
        logic [AW-1:0] ea;
        res_t r;
        if (reset) begin
            pipe.delete();
            outstanding = 0;
            pend_v = 0;
        end else begin
            check("excl_en", 64'(bus.write_enable & bus.read_enable), 64'd0);
            if (pend_v)
                check("hold_stable", 64'({bus.write_enable, bus.read_enable, bus.user_address, bus.user_wdata}), pend);
            pend_v = (bus.write_enable || bus.read_enable) && !bus.req_ready;
            pend = 64'({bus.write_enable, bus.read_enable, bus.user_address, bus.user_wdata});

            if (bus.write_enable && bus.req_ready) begin
                if (exp_q.size() == 0) fail("wr_extra", "write accepted with none expected");
                else begin
                    e = exp_q.pop_front();
                    check("wr_addr", 64'(bus.user_address), 64'(e[AW+DW-1:DW]));
                    check("wr_data", 64'(bus.user_wdata), 64'(e[DW-1:0]));
                end
                mem[bus.user_address] = bus.user_wdata;
            end
            if (bus.read_enable && bus.req_ready) begin
                if (exp_rd_q.size() == 0) fail("rd_extra", "read accepted with none expected");
                else begin
                    ea = exp_rd_q.pop_front();
                    check("rd_addr", 64'(bus.user_address), 64'(ea));
                end
                d = mem.exists(bus.user_address) ? mem[bus.user_address] : '0;
                if (rd_issued == corrupt_idx) d = d ^ corrupt_mask;
                pipe.push_back('{cyc + lat, d});
                rd_issued++;
                outstanding++;
                check("outstanding_cap", 64'(outstanding <= MAXO), 64'd1);
            end
            if (bus.rd_valid && pipe.size() > 0) begin
                void'(pipe.pop_front());
                outstanding--;
                last_rdv = cyc;
            end
            if (done) begin
                done_cnt++;
                if (exp_res_q.size() == 0) fail("done_extra", "done pulse with no test pending");
                else begin
                    r = exp_res_q.pop_front();
                    check("error_count", 64'(error_count), 64'(r.err));
                    check("pass", 64'(pass), 64'(r.p));
                    check("first_err_addr", 64'(first_err_address), 64'(r.fa));
                    check("first_err_data", 64'(first_err_data), 64'(r.fd));
                    if (cur_len > 0) check("done_latency", 64'(cyc - last_rdv), 64'd2);
                end
            end
        end
        cyc++;
    end

    // ---------------- response driver (drive at negedge) ----------------
    always @(negedge clk) begin
        bus.req_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
        if (!reset && pipe.size() > 0 && pipe[0].due <= cyc && cyc >= hold_until) begin
            bus.rd_valid = 1'b1;
            bus.rd_data  = pipe[0].d;
        end else begin
            bus.rd_valid = 1'b0;
            bus.rd_data  = '0;
        end
    end

    task automatic run_test(input int m, input logic [AW-1:0] b, input int n, input bit rr,
                            input int cidx, input logic [DW-1:0] cmask, input bit hold);
        int target;
        logic exp_p;
        rand_ready   = rr;
        corrupt_idx  = cidx;
        corrupt_mask = cmask;
        rd_issued    = 0;
        cur_len      = n;
        exp_p        = !(cidx >= 0 && cidx < n && cmask != '0);
        push_expect(m, b, n, cidx, cmask);
        target = done_cnt + 1;
        @(negedge clk);
        hold_until   = hold ? cyc + n + 25 : 0;
        mode         = 2'(m);
        base_address = b;
        len          = LW'(n);
        start        = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (n > 0) check("start_to_we", 64'(bus.write_enable), 64'd1);
        else       check("len0_done", 64'(done), 64'd1);
        if (hold) begin
            while (cyc < hold_until - 1) @(negedge clk);
            check("stall_reads", 64'(rd_issued), 64'(MAXO));
        end
        for (int k = 0; k < n * 20 + 200 && done_cnt < target; k++) @(negedge clk);
        if (done_cnt < target) fail("done_timeout", "no done pulse within cycle budget");
        check("busy_after", 64'(busy), 64'd0);
        check("pass_held", 64'(pass), 64'(exp_p));
        check("wr_left", 64'(exp_q.size()), 64'd0);
        check("rd_left", 64'(exp_rd_q.size()), 64'd0);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        mode = '0;
        base_address = '0;
        len = '0;
        repeat (3) @(negedge clk);
        check("rst_outputs", 64'({bus.write_enable, bus.read_enable, bus.user_address, bus.user_wdata,
                                  busy, done, pass}), 64'd0);
        check("rst_err", 64'({error_count, first_err_address, first_err_data}), 64'd0);
        check("rst_state", 64'(dbg_state), 64'(ST_IDLE));
        reset = 1'b0;

        lat = 3;
        run_test(0, 18'h0, 16, 0, -1, '0, 0);
        run_test(2, 18'h0, 300, 1, -1, '0, 0);
        run_test(0, 18'h100, 16, 0, 5, 16'h0004, 0);
        run_test(1, 18'h3FFFE, 4, 1, -1, '0, 0);
        run_test(0, 18'h40, 32, 0, -1, '0, 1);

        // Abandon a test mid-READ, then a zero-length test.
        push_expect(0, 18'h200, 64, -1, '0);
        rand_ready = 0;
        corrupt_idx = -1;
        rd_issued = 0;
        @(negedge clk);
        base_address = 18'h200;
        len = 16'd64;
        mode = 2'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 400 && !(dbg_state == ST_READ && rd_issued >= 3); k++) @(negedge clk);
        if (!(dbg_state == ST_READ && rd_issued >= 3)) fail("reach_read", "READ never reached");
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_bus", 64'({bus.write_enable, bus.read_enable, bus.user_address, bus.user_wdata}), 64'd0);
        check("mid_rst_status", 64'({busy, done, pass, error_count, first_err_address, first_err_data}), 64'd0);
        reset = 1'b0;
        exp_q.delete();
        exp_rd_q.delete();
        exp_res_q.delete();
        run_test(3, 18'h55, 0, 0, -1, '0, 0);

        for (int t = 0; t < 6; t++) begin
            int n, ci;
            n   = $urandom_range(1, 40);
            ci  = ($urandom_range(0, 1) == 1) ? $urandom_range(0, n - 1) : -1;
            lat = $urandom_range(1, 5);
            run_test($urandom_range(0, 3), AW'($urandom), n, 1'($urandom_range(0, 1)), ci,
                     DW'($urandom_range(1, 16'hFFFF)), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ddr3_bist.md
# ddr3_bist

Parametrised built-in self-test traffic engine for the DDR3 memory controller: writes a programmable-length region with a selectable data pattern, reads it back, and checks every returned word. It replaces the free-running incrementing-address harness at the top level. It adds a ready/valid request handshake, bounded outstanding reads, four pattern modes, error counting and first-failure capture. It sits between board-level control (buttons/ILA) and `ddr3_memory_controller`'s user port.

## Interface
- `ADDRESS_BITWIDTH`, 15: DDR3 row/column address width.
- `BANK_ADDRESS_BITWIDTH`, 3: bank address width.
- `DQ_BITWIDTH`, 16: user data word width.
- `LEN_BITWIDTH`, 16: width of run-time word count.
- `MAX_OUTSTANDING`, 8: maximum issued-but-unreturned reads; power of two, at least 1.
- `ERR_BITWIDTH`, 16: error counter width; saturating.
- `LFSR_SEED`, 16'hACE1: non-zero LFSR seed.

Ports:
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `start` in 1: begin a test; sampled in IDLE only.
- `mode` in 2: 0 incrementing, 1 walking-one, 2 LFSR, 3 address-as-data; latched at start.
- `base_address` in BANK+ADDR: first user address; latched at start.
- `len` in LEN_BITWIDTH: number of words; latched at start.
- `req_ready` in 1: controller accepts the current request.
- `write_enable` out 1: write request valid.
- `read_enable` out 1: read request valid.
- `user_address` out BANK+ADDR: request address.
- `user_wdata` out DQ: write data.
- `rd_valid` in 1: read data returned, in order.
- `rd_data` in DQ: returned data.
- `busy` out 1: not in IDLE.
- `done` out 1: one-cycle pulse at test end.
- `pass` out 1: last test had zero errors; held until next start.
- `error_count` out ERR: mismatches in last test.
- `first_err_address` out BANK+ADDR: address of first mismatch.
- `first_err_data` out DQ: data of first mismatch.

## Operation
- FSM states: IDLE, WRITE, READ, DRAIN, DONE.
- IDLE → WRITE when `start`; `len`==0 goes IDLE → DONE with `pass`=1. `start` in any other state is ignored.
- On entering WRITE, clear `error_count`, `first_err_*` and `pass`.
- WRITE: `write_enable`=1. Word i is issued at `base_address`+i; advance only on `write_enable`&&`req_ready`. After write `len`-1 is accepted, go to READ.
- READ: `read_enable`=1 while outstanding < `MAX_OUTSTANDING`. After the last read is accepted, go to DRAIN.
- DRAIN → DONE when checked count == `len`.
- DONE: `done`=1 for one cycle, `pass`=(`error_count`==0), then IDLE.
- `write_enable` and `read_enable` are never high together.
- Address wraps modulo 2^(BANK+ADDR).
- Patterns by word index i:
  - Mode 0: i truncated to DQ bits.
  - Mode 1: 1<<(i mod DQ_BITWIDTH).
  - Mode 2: Fibonacci LFSR stepped per word, seeded at start.
  - Mode 3: address zero-extended or truncated to DQ bits.
- The check stream regenerates the expected pattern independently, advancing on each `rd_valid`.
- On mismatch, increment `error_count`, saturating at all-ones. Capture `first_err_*` only when `error_count` was 0.
- `rd_valid` outside READ/DRAIN is ignored.
- Read accept and `rd_valid` in the same cycle leave outstanding unchanged.
- `reset` at any point: return to IDLE and abandon in-flight reads.

## Timing
- Reset values: all outputs 0, state IDLE.
- `start` at cycle n: `write_enable` high at n+1.
- Request outputs hold stable while valid && !`req_ready`.
- Last write accepted at cycle m: `read_enable` may be high at m+1.
- Compare is registered. `error_count` updates 1 cycle after `rd_valid`.
- `done` asserts 2 cycles after the final `rd_valid`: 1 for compare, 1 for DONE.
- With `req_ready`=1 and zero read latency, throughput is 1 request per cycle.

## Structure
- `ddr3_bist_pkg`: state enum, mode encodings (MODE_INC, MODE_WALK, MODE_LFSR, MODE_ADDR), LFSR taps per DQ width.
- Sub-module `ddr3_bist_pattern`: index/address/LFSR to data. Instanced twice, once for the issue stream and once for the check stream.

## Test plan
- Mode 0, `len`=16, base 0, loopback model with 3-cycle latency → 16 writes then 16 reads; `done` pulse; `pass`=1; `error_count`=0.
- Mode 2, `len`=300, random `req_ready` stalls → stable outputs while stalled; `pass`=1. `user_wdata` for word 1 is the LFSR step after `LFSR_SEED`.
- Model corrupts word 5, XOR 16'h0004, base 0x100 → `error_count`=1; `first_err_address`=0x105; `pass`=0.
- Base = max address − 1, `len`=4 → addresses max−1, max, 0, 1.
- Model holds `rd_valid` off for 20 cycles → at most `MAX_OUTSTANDING` reads issued; DRAIN completes once data returns.
- `reset` asserted mid-READ, and `len`=0 → all outputs 0 in the next cycle; `len`=0 yields `done` with `pass`=1 and no requests.
